// File: rtl/regs_pkg.sv
// Shared widths, constants and debug FSM encoding for the tc_l1 register file.
// Also holds the read-port bypass select used by both read ports and the debug path.
package regs_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic                  WriteEnable = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord    = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg     = '0;

  typedef enum logic {
    DbgIdle = 1'b0,
    DbgAck  = 1'b1
  } dbg_state_e;

  // x0 reads as zero; otherwise the committing write wins over the stored value.
  function automatic logic [RegBus-1:0] bypass_sel(
    input logic [RegAddrBus-1:0] addr,
    input logic                  wr_hit,
    input logic [RegAddrBus-1:0] wr_addr,
    input logic [RegBus-1:0]     wr_data,
    input logic [RegBus-1:0]     arr_data
  );
    logic [RegBus-1:0] res;
    res = arr_data;
    if (addr == ZeroReg)
      res = ZeroWord;
    else if (wr_hit && (wr_addr == addr))
      res = wr_data;
    return res;
  endfunction

endpackage

// File: rtl/regs.sv
// 32x32 GPR file: pipeline write port, two bypassed combinational read ports,
// and a single-outstanding debug req/ack port that yields to pipeline writes.
module regs
  import regs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_we_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic [RegBus-1:0]     reg_wdata_i,
  input  logic [RegAddrBus-1:0] raddr1_i,
  output logic [RegBus-1:0]     rdata1_o,
  input  logic [RegAddrBus-1:0] raddr2_i,
  output logic [RegBus-1:0]     rdata2_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [RegAddrBus-1:0] dbg_addr_i,
  input  logic [RegBus-1:0]     dbg_wdata_i,
  output logic                  dbg_ack_o,
  output logic [RegBus-1:0]     dbg_rdata_o
);

  logic [RegNum-1:0][RegBus-1:0] mem_q;
  dbg_state_e                    state_q, state_d;
  logic [RegBus-1:0]             dbg_rdata_q, dbg_rdata_d;

  logic                  dbg_go;
  logic                  wr_en;
  logic                  wr_hit;
  logic [RegAddrBus-1:0] wr_addr;
  logic [RegBus-1:0]     wr_data;

  // A debug write only proceeds when the pipeline leaves the write port free.
  always_comb begin
    state_d = state_q;
    dbg_go  = 1'b0;
    case (state_q)
      DbgIdle: begin
        if (dbg_req_i && (!dbg_we_i || (reg_we_i != WriteEnable))) begin
          dbg_go  = 1'b1;
          state_d = DbgAck;
        end
      end
      DbgAck:  state_d = DbgIdle;
      default: state_d = DbgIdle;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = reg_waddr_i;
    wr_data = reg_wdata_i;
    if (reg_we_i == WriteEnable) begin
      wr_en = 1'b1;
    end else if (dbg_go && dbg_we_i) begin
      wr_en   = 1'b1;
      wr_addr = dbg_addr_i;
      wr_data = dbg_wdata_i;
    end
    wr_hit = wr_en && (wr_addr != ZeroReg);
  end

  assign rdata1_o = bypass_sel(raddr1_i, wr_hit, wr_addr, wr_data, mem_q[raddr1_i]);
  assign rdata2_o = bypass_sel(raddr2_i, wr_hit, wr_addr, wr_data, mem_q[raddr2_i]);

  always_comb begin
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_go && !dbg_we_i)
      dbg_rdata_d = bypass_sel(dbg_addr_i, wr_hit, wr_addr, wr_data, mem_q[dbg_addr_i]);
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++) mem_q[i] <= ZeroWord;
      state_q     <= DbgIdle;
      dbg_rdata_q <= ZeroWord;
    end else begin
      if (wr_hit) mem_q[wr_addr] <= wr_data;
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack_o   = (state_q == DbgAck);
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_regs.sv
// Directed bench for regs: inputs change on the falling edge, combinational
// outputs are checked before the rising edge, registered ones just after it.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        dbg_req_i, dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regs dut (
    .clk(clk), .rst(rst),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
  );

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    reg_we_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'hFFFF_0000;
    edge_settle();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    raddr1_i = 5'd5; raddr2_i = 5'd0;
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd1_x5 got %h exp %h", rdata1_o, 32'h0); end
    n_checks++; if (rdata2_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd2_x0 got %h exp %h", rdata2_o, 32'h0); end
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", dbg_ack_o); end
    n_checks++; if (dbg_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_rdata got %h exp %h", dbg_rdata_o, 32'h0); end
  endtask

  task automatic test_pipe_write();
    @(negedge clk);
    reg_we_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'hDEAD_BEEF;
    raddr1_i = 5'd3; raddr2_i = 5'd4;
    #1;
    n_checks++; if (rdata1_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pipe_bypass got %h exp %h", rdata1_o, 32'hDEAD_BEEF); end
    n_checks++; if (rdata2_o !== 32'h0) begin n_fail++; $display("FAIL pipe_other_port got %h exp %h", rdata2_o, 32'h0); end
    edge_settle();
    @(negedge clk);
    reg_we_i = 1'b0;
    #1;
    n_checks++; if (rdata1_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pipe_array_c1 got %h exp %h", rdata1_o, 32'hDEAD_BEEF); end
    edge_settle();
    n_checks++; if (rdata1_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pipe_array_c2 got %h exp %h", rdata1_o, 32'hDEAD_BEEF); end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    reg_we_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 32'h1234_5678;
    raddr1_i = 5'd0; raddr2_i = 5'd0;
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL x0_bypass_rd1 got %h exp %h", rdata1_o, 32'h0); end
    n_checks++; if (rdata2_o !== 32'h0) begin n_fail++; $display("FAIL x0_bypass_rd2 got %h exp %h", rdata2_o, 32'h0); end
    edge_settle();
    @(negedge clk);
    reg_we_i = 1'b0; raddr2_i = 5'd3;
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL x0_after_rd1 got %h exp %h", rdata1_o, 32'h0); end
    n_checks++; if (rdata2_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_x3_intact got %h exp %h", rdata2_o, 32'hDEAD_BEEF); end
  endtask

  task automatic test_dbg_blocked_write();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'hA5A5_A5A5;
      reg_we_i = 1'b1; reg_waddr_i = 5'd10 + 5'(i); reg_wdata_i = 32'h100 + 32'(i);
      raddr1_i = 5'd7;
      #1;
      n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL blk_no_write_%0d got %h exp %h", i, rdata1_o, 32'h0); end
      edge_settle();
      n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL blk_no_ack_%0d got %b exp 0", i, dbg_ack_o); end
    end
    @(negedge clk);
    reg_we_i = 1'b0;
    #1;
    n_checks++; if (rdata1_o !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL blk_dbg_bypass got %h exp %h", rdata1_o, 32'hA5A5_A5A5); end
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b1) begin n_fail++; $display("FAIL blk_ack got %b exp 1", dbg_ack_o); end
    @(negedge clk);
    idle_inputs();
    raddr1_i = 5'd7; raddr2_i = 5'd10;
    #1;
    n_checks++; if (rdata1_o !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL blk_x7 got %h exp %h", rdata1_o, 32'hA5A5_A5A5); end
    n_checks++; if (rdata2_o !== 32'h100) begin n_fail++; $display("FAIL blk_x10 got %h exp %h", rdata2_o, 32'h100); end
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL blk_ack_drop got %b exp 0", dbg_ack_o); end
    @(negedge clk);
    raddr1_i = 5'd11; raddr2_i = 5'd12;
    #1;
    n_checks++; if (rdata1_o !== 32'h101) begin n_fail++; $display("FAIL blk_x11 got %h exp %h", rdata1_o, 32'h101); end
    n_checks++; if (rdata2_o !== 32'h102) begin n_fail++; $display("FAIL blk_x12 got %h exp %h", rdata2_o, 32'h102); end
  endtask

  task automatic test_dbg_read_bypass();
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd9;
    reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'h0000_0042;
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b1) begin n_fail++; $display("FAIL rdbyp_ack got %b exp 1", dbg_ack_o); end
    n_checks++; if (dbg_rdata_o !== 32'h42) begin n_fail++; $display("FAIL rdbyp_data got %h exp %h", dbg_rdata_o, 32'h42); end
    @(negedge clk);
    idle_inputs();
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL rdbyp_ack_drop got %b exp 0", dbg_ack_o); end
    n_checks++; if (dbg_rdata_o !== 32'h42) begin n_fail++; $display("FAIL rdbyp_hold got %h exp %h", dbg_rdata_o, 32'h42); end
  endtask

  // Req left high across the ack is taken as a second access.
  task automatic test_back_to_back();
    logic [2:0] exp_ack;
    exp_ack = 3'b101;
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      n_checks++; if (dbg_ack_o !== exp_ack[i]) begin n_fail++; $display("FAIL b2b_ack_%0d got %b exp %b", i, dbg_ack_o, exp_ack[i]); end
    end
    n_checks++; if (dbg_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_data got %h exp %h", dbg_rdata_o, 32'hDEAD_BEEF); end
    @(negedge clk);
    idle_inputs();
    edge_settle();
  endtask

  task automatic test_dbg_x0_write();
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFF_FFFF;
    raddr1_i = 5'd0;
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL dbgx0_bypass got %h exp %h", rdata1_o, 32'h0); end
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b1) begin n_fail++; $display("FAIL dbgx0_ack got %b exp 1", dbg_ack_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL dbgx0_read got %h exp %h", rdata1_o, 32'h0); end
    edge_settle();
  endtask

  task automatic test_rst_abort();
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd20; dbg_wdata_i = 32'h0000_CAFE;
    rst = 1'b1;
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack got %b exp 0", dbg_ack_o); end
    n_checks++; if (dbg_rdata_o !== 32'h0) begin n_fail++; $display("FAIL abort_rdata_clr got %h exp %h", dbg_rdata_o, 32'h0); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    raddr1_i = 5'd20; raddr2_i = 5'd3;
    #1;
    n_checks++; if (rdata1_o !== 32'h0) begin n_fail++; $display("FAIL abort_x20 got %h exp %h", rdata1_o, 32'h0); end
    n_checks++; if (rdata2_o !== 32'h0) begin n_fail++; $display("FAIL abort_x3_clr got %h exp %h", rdata2_o, 32'h0); end
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b exp 0", dbg_ack_o); end
    // FSM must be in IDLE: a fresh read acks in exactly one cycle.
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd20;
    edge_settle();
    n_checks++; if (dbg_ack_o !== 1'b1) begin n_fail++; $display("FAIL abort_new_ack got %b exp 1", dbg_ack_o); end
    @(negedge clk);
    idle_inputs();
    edge_settle();
  endtask

  initial begin
    rst = 1'b1;
    raddr1_i = '0; raddr2_i = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_pipe_write();
    test_x0_write();
    test_dbg_blocked_write();
    test_dbg_read_bypass();
    test_back_to_back();
    test_dbg_x0_write();
    test_rst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
